// File: rtl/div_r4_pkg.sv
// Shared types and constants for the radix-4 sequential divider.
package div_r4_pkg;

   localparam int unsigned DIV_N       = 8;
   localparam int unsigned CALC_CYCLES = DIV_N;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      CALC   = 2'd1,
      UNLOAD = 2'd2
   } state_t;

   // Operand byte order on the input channel
   localparam logic [1:0] LD_DVD_HI = 2'd0;
   localparam logic [1:0] LD_DVD_LO = 2'd1;
   localparam logic [1:0] LD_DVS    = 2'd2;

   // Result byte order on the output channel
   localparam logic [1:0] UL_QUO_HI = 2'd0;
   localparam logic [1:0] UL_QUO_LO = 2'd1;
   localparam logic [1:0] UL_REM    = 2'd2;

endpackage

// File: rtl/div_r4_digit.sv
// One radix-4 restoring step: picks the largest of 3D/2D/D not above the
// partial remainder and returns the quotient digit and reduced remainder.
module div_r4_digit
   import div_r4_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic [N+1:0] pr,
   input  logic [N-1:0] d,
   output logic [1:0]   digit,
   output logic [N-1:0] rem_nx
);

   localparam int unsigned PW = N + 2;

   logic [PW-1:0] d1;
   logic [PW-1:0] d2;
   logic [PW-1:0] d3;
   logic [PW-1:0] diff;

   // With d=0 every compare passes, so digit is 3 and the remainder just
   // shifts the dividend through, leaving dividend[N-1:0] after N steps.
   always_comb begin
      d1    = PW'(d);
      d2    = d1 << 1;
      d3    = d1 + d2;
      digit = 2'd0;
      diff  = pr;
      if (pr >= d3) begin
         digit = 2'd3;
         diff  = pr - d3;
      end else if (pr >= d2) begin
         digit = 2'd2;
         diff  = pr - d2;
      end else if (pr >= d1) begin
         digit = 2'd1;
         diff  = pr - d1;
      end
      rem_nx = N'(diff);
   end

endmodule

// File: rtl/div_r4_seq.sv
// Byte-serial 2N/N radix-4 divider: loads dividend hi/lo and divisor, iterates
// N cycles, then unloads quotient hi/lo and remainder. Option: DIV_R4_ZERO_BYPASS_EN.
module div_r4_seq
   import div_r4_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   input  logic         out_ready,
   output logic         dz,
   output logic         busy
);

   localparam int unsigned QW = 2 * N;
   localparam int unsigned CW = $clog2(N + 1);

   state_t         state, state_nx;
   logic [QW-1:0]  q, q_nx;
   logic [N-1:0]   rem, rem_nx;
   logic [N-1:0]   dvs, dvs_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic [1:0]     idx, idx_nx;
   logic           in_ready_nx;
   logic           out_valid_nx;
   logic [N-1:0]   out_data_nx;
   logic           dz_nx;
   logic           busy_nx;

   logic [N+1:0]   pr;
   logic [1:0]     digit;
   logic [N-1:0]   dig_rem;

   // q holds the dividend and fills with quotient digits from the bottom
   assign pr = {rem, q[QW-1:QW-2]};

   div_r4_digit #(.N(N)) u_digit (
      .pr     (pr),
      .d      (dvs),
      .digit  (digit),
      .rem_nx (dig_rem)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOAD;
         q         <= '0;
         rem       <= '0;
         dvs       <= '0;
         cnt       <= '0;
         idx       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         dz        <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         q         <= q_nx;
         rem       <= rem_nx;
         dvs       <= dvs_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         in_ready  <= in_ready_nx;
         out_valid <= out_valid_nx;
         out_data  <= out_data_nx;
         dz        <= dz_nx;
         busy      <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      q_nx     = q;
      rem_nx   = rem;
      dvs_nx   = dvs;
      cnt_nx   = cnt;
      idx_nx   = idx;
      dz_nx    = dz;

      case (state)
         LOAD: begin
            if (in_valid && in_ready) begin
               idx_nx = idx + 2'd1;
               case (idx)
                  LD_DVD_HI: q_nx[QW-1:N] = in_data;
                  LD_DVD_LO: q_nx[N-1:0]  = in_data;
                  default: begin
                     dvs_nx   = in_data;
                     rem_nx   = '0;
                     cnt_nx   = '0;
                     idx_nx   = '0;
                     dz_nx    = (in_data == '0);
                     state_nx = CALC;
`ifdef DIV_R4_ZERO_BYPASS_EN
                     if (in_data == '0) begin
                        state_nx = UNLOAD;
                        q_nx     = '1;
                        rem_nx   = q[N-1:0];
                     end
`endif
                  end
               endcase
            end
         end

         CALC: begin
            q_nx   = {q[QW-3:0], digit};
            rem_nx = dig_rem;
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
               state_nx = UNLOAD;
               idx_nx   = '0;
            end
         end

         UNLOAD: begin
            if (out_valid && out_ready) begin
               if (idx == UL_REM) begin
                  state_nx = LOAD;
                  idx_nx   = '0;
                  dz_nx    = 1'b0;
               end else begin
                  idx_nx = idx + 2'd1;
               end
            end
         end

         default: begin
            state_nx = LOAD;
            idx_nx   = '0;
         end
      endcase

      // Outputs are registered; out_valid lags UNLOAD entry by one cycle
      in_ready_nx  = (state_nx == LOAD);
      busy_nx      = (state_nx != LOAD);
      out_valid_nx = (state == UNLOAD) && (state_nx == UNLOAD);
      out_data_nx  = '0;
      if (state_nx == UNLOAD) begin
         case (idx_nx)
            UL_QUO_HI: out_data_nx = q_nx[QW-1:N];
            UL_QUO_LO: out_data_nx = q_nx[N-1:0];
            default:   out_data_nx = rem_nx;
         endcase
      end
   end

endmodule

// File: doc/div_r4_seq.md
DIV_R4_SEQ -- requirements
Module: div_r4_seq

Interface
REQ-001 SHALL have parameter N, default 8, giving divisor width, remainder width and bus byte width; the dividend and quotient are 2N bits wide.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the in_data byte is offered.
REQ-005 SHALL have port in_data, input, N, the operand byte.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand byte.
REQ-007 SHALL have port out_valid, output, 1, meaning the out_data byte is offered.
REQ-008 SHALL have port out_data, output, N, the result byte.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result byte.
REQ-010 SHALL have port dz, output, 1, the divide-by-zero flag; valid while out_valid=1.
REQ-011 SHALL have port busy, output, 1, high in CALC and UNLOAD.

Function
REQ-012 SHALL transfer a byte only on an edge where valid=1 and ready=1 on that channel.
REQ-013 SHALL implement FSM states LOAD, CALC and UNLOAD, where reset enters LOAD.
REQ-014 In LOAD, SHALL hold in_ready=1 and accept, in order, dividend high byte, dividend low byte, then divisor, using a 2-bit byte counter.
REQ-015 On acceptance of the divisor byte, SHALL go to CALC with partial remainder=0 and the iteration counter=0.
REQ-016 In CALC, SHALL retire 2 quotient bits per cycle, MSB first, as follows: shift the next 2 dividend bits into the N+2-bit partial remainder; compare it with 3D, 2D and D; subtract the largest multiple that is not greater; and record digit 3, 2, 1 or 0.
REQ-017 SHALL complete CALC in exactly N cycles (8 at default), so out_valid rises 9 edges after the edge that accepts the divisor byte.
REQ-018 In UNLOAD, SHALL present, in order, quotient high byte, quotient low byte, then remainder, and hold each byte and dz stable while out_ready=0.
REQ-019 After the third output byte transfers, SHALL return to LOAD, with in_ready=1 on the next cycle.
REQ-020 SHALL keep in_ready=0 outside LOAD, so an in_valid in the same cycle as the final output transfer is not accepted.
REQ-021 SHALL ignore in_valid outside LOAD and ignore out_ready outside UNLOAD.
REQ-022 For divisor=0, SHALL set dz=1 with quotient=all ones and remainder=dividend[N-1:0].
REQ-023 For a nonzero divisor, SHALL produce quotient and remainder satisfying dividend = Q*D + R with R < D; no overflow is possible.

Reset
REQ-024 rst=0 SHALL asynchronously force the LOAD state, clear all counters, the remainder register and the quotient register, and set in_ready=1, out_valid=0, out_data=0, dz=0 and busy=0.
REQ-025 Reset asserted mid-CALC or mid-UNLOAD SHALL discard the operation; no partial result may appear afterwards.

Configuration
REQ-026 SHALL use macro DIV_R4_ZERO_BYPASS_EN.
REQ-027 With DIV_R4_ZERO_BYPASS_EN defined, divisor=0 SHALL skip CALC and go directly to UNLOAD, with out_valid rising 1 edge after divisor acceptance.
REQ-028 Without DIV_R4_ZERO_BYPASS_EN, divisor=0 SHALL run the full N CALC cycles; the REQ-022 results and dz are identical in both builds.

Structure
REQ-029 Package div_r4_pkg SHALL hold the FSM state typedef, the constant CALC_CYCLES=N, and byte-index constants for the load order and unload order.
REQ-030 SHALL use one combinational sub-module, div_r4_digit, which takes the partial remainder and divisor and returns the quotient digit and the next remainder; the CALC datapath instantiates it once.

Verification
REQ-031 Load 0x03,0xE8,0x07 (1000/7): outputs 0x00,0x8E,0x06, with dz=0 and out_valid 9 edges after divisor acceptance.
REQ-032 Load 0xFF,0xFF,0xFF: outputs 0x01,0x01,0x00.
REQ-033 Load 0x00,0x05,0x09: outputs 0x00,0x00,0x05.
REQ-034 Load 0x12,0x34,0x00: outputs 0xFF,0xFF,0x34 with dz=1; latency is 1 edge with the macro defined and 9 edges without it.
REQ-035 Run 1000/7 with out_ready=0 for 3 cycles on each byte: each byte is held stable, and a following back-to-back operation gives the correct result.
REQ-036 Assert rst for 1 cycle at CALC cycle 4: in_ready=1 and out_valid=0 immediately, and the next operation of 65535/255 is correct.
